// File: rtl/phy_rx_lane.sv
// Serial receive lane: bit-slides onto the COMMA symbol, confirms alignment over BC_COUNT
// consecutive COMMA bytes, then emits each non-COMMA byte with a one-cycle valid pulse.
// Optional macro PHYRX_BC_CNT_EN adds bc_total, a saturating count of idle COMMA bytes seen while active.
module phy_rx_lane #(
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int unsigned BC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active_out,
  output logic [1:0] state_dbg
`ifdef PHYRX_BC_CNT_EN
  ,
  output logic [7:0] bc_total
`endif
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] BC_LIMIT = 4'(BC_COUNT);

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_seen_q, bc_seen_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;
`ifdef PHYRX_BC_CNT_EN
  logic [7:0] bc_total_q, bc_total_d;
`endif

  // nxt is the byte whose last bit is being sampled on this edge.
  logic [7:0] nxt;
  logic       is_comma;
  logic       byte_done;
  logic [3:0] bc_seen_inc;
  logic       bc_reached;

  assign nxt         = {sr_q[6:0], data_in};
  assign is_comma    = (nxt == COMMA);
  assign byte_done   = (bit_cnt_q == 3'd7);
  assign bc_seen_inc = (bc_seen_q >= BC_LIMIT) ? BC_LIMIT : (bc_seen_q + 4'd1);
  assign bc_reached  = (bc_seen_inc == BC_LIMIT);

  // State register.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q <= ST_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEARCH: begin
        if (is_comma) begin
          state_d = (BC_LIMIT == 4'd1) ? ST_ACTIVE : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (byte_done) begin
          if (!is_comma) begin
            state_d = ST_SEARCH;
          end else if (bc_reached) begin
            state_d = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        state_d = ST_ACTIVE;
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    sr_d      = nxt;
    bit_cnt_d = bit_cnt_q + 3'd1;
    bc_seen_d = bc_seen_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    active_d  = active_q;
`ifdef PHYRX_BC_CNT_EN
    bc_total_d = bc_total_q;
`endif
    case (state_q)
      ST_SEARCH: begin
        // Hold the bit counter at zero so a match restarts byte framing from here.
        bit_cnt_d = 3'd0;
        if (is_comma) begin
          bc_seen_d = 4'd1;
          if (BC_LIMIT == 4'd1) begin
            active_d = 1'b1;
          end
        end
      end
      ST_ALIGN: begin
        if (byte_done) begin
          if (is_comma) begin
            bc_seen_d = bc_seen_inc;
            if (bc_reached) begin
              active_d = 1'b1;
            end
          end else begin
            bc_seen_d = 4'd0;
          end
        end
      end
      ST_ACTIVE: begin
        if (byte_done) begin
          if (!is_comma) begin
            data_d  = nxt;
            valid_d = 1'b1;
          end
`ifdef PHYRX_BC_CNT_EN
          else if (bc_total_q != 8'hFF) begin
            bc_total_d = bc_total_q + 8'd1;
          end
`endif
        end
      end
      default: begin
        bc_seen_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_seen_q <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_seen_q <= bc_seen_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
    end
  end

`ifdef PHYRX_BC_CNT_EN
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      bc_total_q <= 8'h00;
    end else begin
      bc_total_q <= bc_total_d;
    end
  end

  assign bc_total = bc_total_q;
`endif

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign active_out = active_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_phy_rx_lane.sv
// Self-checking bench for phy_rx_lane: bit streams are scored against a stream-level
// model that locates the COMMA run and predicts every data byte and its cycle.
module tb_phy_rx_lane;

  localparam logic [7:0] COMMA    = 8'hBC;
  localparam int         BC_COUNT = 4;
  localparam int         MAXN     = 4096;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active_out;
  logic [1:0] state_dbg;
`ifdef PHYRX_BC_CNT_EN
  logic [7:0] bc_total;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  bit         stim_q[$];
  logic [7:0] exp_q[$];
  bit         exp_valid [MAXN];
  logic [7:0] exp_byte  [MAXN];
  int         exp_active_at;
  int         exp_idle;

  // Clock / reset
  always #5 clk_32f = ~clk_32f;

  phy_rx_lane #(
    .COMMA   (COMMA),
    .BC_COUNT(BC_COUNT)
  ) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active_out(active_out),
    .state_dbg (state_dbg)
`ifdef PHYRX_BC_CNT_EN
    ,
    .bc_total  (bc_total)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Driver helpers: build the serial stream, MSB first.
  task automatic push_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) stim_q.push_back(b[k]);
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) stim_q.push_back(v[k]);
  endtask

  // Eight most recent bits ending at stream index i; the line idles low before the stream.
  function automatic logic [7:0] window(input int i);
    logic [7:0] w = 8'h00;
    for (int k = i - 7; k <= i; k++) w = {w[6:0], (k >= 0) ? stim_q[k] : 1'b0};
    return w;
  endfunction

  // Reference model: find the first COMMA anywhere, require BC_COUNT COMMAs on
  // consecutive 8-bit boundaries, otherwise resume the search one bit after the bad byte.
  task automatic build_model();
    int n;
    int i;
    int j;
    int cnt;
    logic [7:0] w;
    n = stim_q.size();
    for (int k = 0; k < MAXN; k++) exp_valid[k] = 1'b0;
    exp_active_at = -1;
    exp_idle      = 0;
    i = 0;
    while (i < n && exp_active_at < 0) begin
      if (window(i) != COMMA) begin
        i++;
      end else begin
        cnt = 1;
        j   = i;
        if (cnt == BC_COUNT) exp_active_at = i;
        while (exp_active_at < 0) begin
          j += 8;
          if (j >= n) break;
          if (window(j) != COMMA) break;
          cnt++;
          if (cnt == BC_COUNT) exp_active_at = j;
        end
        i = j + 1;
      end
    end
    if (exp_active_at >= 0) begin
      for (int k = exp_active_at + 8; k < n; k += 8) begin
        w = window(k);
        if (w != COMMA) begin
          exp_valid[k] = 1'b1;
          exp_byte[k]  = w;
          exp_q.push_back(w);
        end else begin
          exp_idle++;
        end
      end
    end
  endtask

  task automatic apply_reset(input string name, input int cycles);
    reset = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      data_in = 1'($urandom_range(0, 1));
      @(posedge clk_32f);
      #1;
    end
    check({name, ":rst_valid"}, valid_out, 0);
    check({name, ":rst_active"}, active_out, 0);
    check({name, ":rst_data"}, data_out, 0);
`ifdef PHYRX_BC_CNT_EN
    check({name, ":rst_bc_total"}, bc_total, 0);
`endif
    reset = 1'b0;
  endtask

  // Scoreboard: per-cycle valid/active/data plus in-order byte queue.
  task automatic run_segment(input string name, input int rst_cycles);
    logic [7:0] held;
    int pulses;
    int exp_pulses;
    int n;
    held   = 8'h00;
    pulses = 0;
    build_model();
    exp_pulses = exp_q.size();
    n = stim_q.size();
    apply_reset(name, rst_cycles);
    for (int i = 0; i < n; i++) begin
      data_in = stim_q[i];
      @(posedge clk_32f);
      #1;
      if (exp_valid[i]) held = exp_byte[i];
      check({name, ":valid"}, valid_out, exp_valid[i]);
      check({name, ":active"}, active_out, (exp_active_at >= 0 && i >= exp_active_at) ? 1 : 0);
      check({name, ":data_hold"}, data_out, held);
      if (valid_out === 1'b1) begin
        pulses++;
        if (exp_q.size() > 0) check({name, ":byte"}, data_out, exp_q.pop_front());
      end
    end
    check({name, ":pulses"}, pulses, exp_pulses);
`ifdef PHYRX_BC_CNT_EN
    check({name, ":bc_total"}, bc_total, (exp_idle > 255) ? 255 : exp_idle);
`endif
    stim_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int junk;
    int nbytes;
    logic [7:0] b;

    // Alignment with no offset.
    for (int k = 0; k < 4; k++) push_byte(COMMA);
    push_byte(8'h5A);
    push_bits(0, 4);
    run_segment("align0", 2);

    // Alignment at a 3-bit offset.
    push_bits(3'b101, 3);
    for (int k = 0; k < 4; k++) push_byte(COMMA);
    push_byte(8'h12);
    push_byte(8'h34);
    run_segment("offset3", 2);

    // Broken COMMA run.
    push_byte(COMMA);
    push_byte(COMMA);
    push_byte(8'h00);
    for (int k = 0; k < 4; k++) push_byte(COMMA);
    push_byte(8'hC3);
    run_segment("broken", 2);

    // Idle COMMAs while active.
    for (int k = 0; k < 4; k++) push_byte(COMMA);
    push_byte(8'hAA);
    push_byte(COMMA);
    push_byte(COMMA);
    push_byte(8'h55);
    run_segment("idle", 2);

    // Active, then reset in the middle of 0x77.
    for (int k = 0; k < 4; k++) push_byte(COMMA);
    push_byte(8'h66);
    push_bits(4'h7, 4);
    run_segment("pre_rst", 2);
    for (int k = 0; k < 3; k++) push_byte(COMMA);
    push_byte(8'h11);
    for (int k = 0; k < 4; k++) push_byte(COMMA);
    push_byte(8'h22);
    run_segment("mid_rst", 1);

    // Back-to-back data bytes.
    for (int k = 0; k < 4; k++) push_byte(COMMA);
    for (int k = 1; k <= 16; k++) push_byte(8'(k));
    run_segment("b2b", 2);

    // Random streams: junk, optional broken run, COMMA run, mixed data/idle.
    for (int s = 0; s < 12; s++) begin
      junk = $urandom_range(0, 12);
      for (int k = 0; k < junk; k++) stim_q.push_back(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < $urandom_range(1, 3); k++) push_byte(COMMA);
        push_byte(8'($urandom_range(0, 255)));
      end
      for (int k = 0; k < BC_COUNT; k++) push_byte(COMMA);
      nbytes = $urandom_range(8, 40);
      for (int k = 0; k < nbytes; k++) begin
        b = ($urandom_range(0, 3) == 0) ? COMMA : 8'($urandom_range(0, 255));
        push_byte(b);
      end
      push_bits(32'($urandom), $urandom_range(0, 7));
      run_segment($sformatf("rand%0d", s), $urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
